// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined ALU.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND  = 3'b000;
    localparam alu_op_t OP_OR   = 3'b001;
    localparam alu_op_t OP_ADD  = 3'b010;
    localparam alu_op_t OP_SUB  = 3'b011;
    localparam alu_op_t OP_XOR  = 3'b100;
    localparam alu_op_t OP_NOR  = 3'b101;
    localparam alu_op_t OP_SLT  = 3'b110;
    localparam alu_op_t OP_SLTU = 3'b111;

    function automatic logic op_is_arith(alu_op_t op);
        return op inside {OP_ADD, OP_SUB, OP_SLT, OP_SLTU};
    endfunction

    // Subtract-style ops feed ~b with carry-in 1 into the adder chain.
    function automatic logic op_inv_b(alu_op_t op);
        return op inside {OP_SUB, OP_SLT, OP_SLTU};
    endfunction

endpackage

// File: rtl/pipe_alu_if.sv
// Operand/result handshake bundle for pipe_alu.
interface pipe_alu_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    alu_op_t          in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_carry;
    logic             out_overflow;
    logic             out_negative;

    modport master (
        output flush, in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag, out_zero, out_carry, out_overflow,
               out_negative
    );

    modport slave (
        input  flush, in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag, out_zero, out_carry, out_overflow,
               out_negative
    );

endinterface

// File: rtl/alu_slice_add.sv
// One slice of the segmented adder: sum, carry-out and carry into the slice MSB.
module alu_slice_add #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    output logic [SLICE-1:0] sum_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [SLICE:0] full;

    always_comb begin
        full = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, c_i};
    end

    assign sum_o   = full[SLICE-1:0];
    assign c_o     = full[SLICE];
    // Recover the carry into the MSB from the MSB's own sum bit.
    assign c_msb_o = sum_o[SLICE-1] ^ a_i[SLICE-1] ^ b_i[SLICE-1];

endmodule

// File: rtl/pipe_alu.sv
// Pipelined ALU: one adder slice per stage, global stall, tag passthrough and flush.
module pipe_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 4
) (
    input logic       clk,
    input logic       rst_n,
    pipe_alu_if.slave bus
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;
    // The last stage writes the output register, so only STAGES-1 inner registers exist.
    localparam int unsigned NREG  = (STAGES > 1) ? STAGES - 1 : 1;

    logic en;

    // Stage inputs: stage 0 from the bus, stage k from inner register k-1.
    logic             st_vld [STAGES];
    alu_op_t          st_op  [STAGES];
    logic [TAG_W-1:0] st_tag [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_res [STAGES];
    logic             st_cin [STAGES];

    logic [SLICE-1:0] sum    [STAGES];
    logic             cout   [STAGES];
    logic             cmsb   [STAGES];
    logic [WIDTH-1:0] nres   [STAGES];

    logic             vld_q  [NREG];
    alu_op_t          op_q   [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [WIDTH-1:0] a_q    [NREG];
    logic [WIDTH-1:0] b_q    [NREG];
    logic [WIDTH-1:0] res_q  [NREG];
    logic             cy_q   [NREG];

    logic             out_vld_q;
    logic [WIDTH-1:0] out_y_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             zero_q, carry_q, ovf_q, neg_q;

    logic [WIDTH-1:0] y_d;
    logic             carry_d, ovf_d, ovf_add;

    assign en = !out_vld_q || bus.out_ready;

    always_comb begin
        st_vld[0] = bus.in_valid;
        st_op[0]  = bus.in_op;
        st_tag[0] = bus.in_tag;
        st_a[0]   = bus.in_a;
        st_b[0]   = op_inv_b(bus.in_op) ? ~bus.in_b : bus.in_b;
        st_cin[0] = op_inv_b(bus.in_op);
        case (bus.in_op)
            OP_AND:  st_res[0] = bus.in_a & bus.in_b;
            OP_OR:   st_res[0] = bus.in_a | bus.in_b;
            OP_XOR:  st_res[0] = bus.in_a ^ bus.in_b;
            OP_NOR:  st_res[0] = ~(bus.in_a | bus.in_b);
            default: st_res[0] = '0;
        endcase
        for (int k = 1; k < int'(STAGES); k++) begin
            st_vld[k] = vld_q[k-1];
            st_op[k]  = op_q[k-1];
            st_tag[k] = tag_q[k-1];
            st_a[k]   = a_q[k-1];
            st_b[k]   = b_q[k-1];
            st_res[k] = res_q[k-1];
            st_cin[k] = cy_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        alu_slice_add #(
            .SLICE (SLICE)
        ) u_add (
            .a_i     (st_a[k][k*SLICE +: SLICE]),
            .b_i     (st_b[k][k*SLICE +: SLICE]),
            .c_i     (st_cin[k]),
            .sum_o   (sum[k]),
            .c_o     (cout[k]),
            .c_msb_o (cmsb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            nres[k] = st_res[k];
            if (op_is_arith(st_op[k])) begin
                nres[k][k*SLICE +: SLICE] = sum[k];
            end
        end
    end

    always_comb begin
        ovf_add = cmsb[LAST] ^ cout[LAST];
        y_d     = nres[LAST];
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (st_op[LAST])
            OP_ADD, OP_SUB: begin
                carry_d = cout[LAST];
                ovf_d   = ovf_add;
            end
            OP_SLT: begin
                y_d     = '0;
                y_d[0]  = nres[LAST][WIDTH-1] ^ ovf_add;
                carry_d = cout[LAST];
            end
            OP_SLTU: begin
                y_d     = '0;
                y_d[0]  = !cout[LAST];
                carry_d = cout[LAST];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NREG); k++) begin
                vld_q[k] <= 1'b0;
                op_q[k]  <= OP_AND;
                tag_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
                cy_q[k]  <= 1'b0;
            end
            out_vld_q <= 1'b0;
            out_y_q   <= '0;
            out_tag_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            if (en) begin
                for (int k = 0; k < int'(STAGES) - 1; k++) begin
                    vld_q[k] <= st_vld[k];
                    op_q[k]  <= st_op[k];
                    tag_q[k] <= st_tag[k];
                    a_q[k]   <= st_a[k];
                    b_q[k]   <= st_b[k];
                    res_q[k] <= nres[k];
                    cy_q[k]  <= cout[k];
                end
                out_vld_q <= st_vld[LAST];
                // Bubbles leave the visible result untouched.
                if (st_vld[LAST]) begin
                    out_y_q   <= y_d;
                    out_tag_q <= st_tag[LAST];
                    zero_q    <= (y_d == '0);
                    carry_q   <= carry_d;
                    ovf_q     <= ovf_d;
                    neg_q     <= y_d[WIDTH-1];
                end
            end
            if (bus.flush) begin
                for (int k = 0; k < int'(NREG); k++) begin
                    vld_q[k] <= 1'b0;
                end
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = en;
    assign bus.out_valid    = out_vld_q;
    assign bus.out_y        = out_y_q;
    assign bus.out_tag      = out_tag_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_carry    = carry_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_negative = neg_q;

endmodule

// File: doc/pipe_alu.md
Name: pipe_alu

Overview:
- Parametrised, pipelined successor to the lab-1 combinational ALU.
- Adds a valid/ready handshake, per-result status flags, a tag passthrough and flush.
- ADD/SUB use a segmented carry-chained adder: each pipeline stage adds one WIDTH/STAGES-bit slice. The whole pipeline stalls on backpressure.
- Sits between the operand source (test driver or future datapath issue logic) and the result sink.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and adder slice count; legal range 1..8.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- in_op  in  3  opcode
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- out_y  out  WIDTH  result
- out_tag  out  TAG_W  tag of the result
- out_zero  out  1  out_y == 0
- out_carry  out  1  adder carry-out (ADD/SUB/SLT/SLTU), else 0
- out_overflow  out  1  signed overflow (ADD/SUB only), else 0
- out_negative  out  1  out_y[WIDTH-1]

Behaviour:
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 011 SUB (a + ~b + 1), 100 XOR, 101 NOR.
  - 110 SLT: signed a<b, result 1 or 0.
  - 111 SLTU: unsigned a<b, result 1 or 0.
- Reset: all stage valid bits = 0; out_valid = 0.
  - out_y, out_tag and all flags = 0.
  - in_ready = 1 after reset deasserts.
- Global enable: en = !out_valid | out_ready.
  - in_ready = en.
  - When en = 0, every stage register holds.
- Latency: exactly STAGES cycles from the accept edge to out_valid = 1 when unstalled. Throughput is 1 op/cycle.
- Stage k (k = 0..STAGES-1) adds slice k using the carry registered from stage k-1.
  - Stage 0 carry-in = 0 for ADD and 1 for SUB/SLT/SLTU. For SUB/SLT/SLTU, b is inverted at entry.
  - Upper operand slices and completed lower result slices are carried forward in stage registers.
- Logic ops are computed in stage 0; the result is carried unchanged through the remaining stages.
- Final stage:
  - carry = carry-out of the top slice.
  - overflow = carry into MSB xor carry-out (ADD/SUB).
  - SLT = sum[MSB] xor overflow.
  - SLTU = !carry.
  - Flags are computed from the final out_y.
- Bubbles: a stage whose valid = 0 still advances when en = 1. Its data is don't-care, but out_* only change when a valid result is loaded.
- Output register: holds out_y, out_tag and flags stable while out_valid & !out_ready.
- flush:
  - Clears all valid bits, including out_valid, on the next edge.
  - Overrides an accept in the same cycle; that op is dropped.
  - Data registers are not cleared.
- Reset asserted mid-operation: all in-flight ops are lost immediately (asynchronous); no partial result appears.
- STAGES = 1: degenerates to a single registered full-width ALU with latency 1.
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package alu_pkg: 3-bit opcode localparams (OP_AND..OP_SLTU) and the opcode typedef.
- One sub-module, alu_slice_add: combinational SLICE-bit adder with carry-in, carry-out and carry-into-MSB. It is instantiated once per stage.

Test Plan:
- ADD a = 1, b = -1 (0xFFFFFFFF), tag = 3 -> after 4 cycles: out_y = 0, zero = 1, carry = 1, overflow = 0, negative = 0, out_tag = 3.
- ADD 0x7FFFFFFF + 1 -> out_y = 0x80000000, overflow = 1, negative = 1, carry = 0. SUB 0 - 1 -> out_y = 0xFFFFFFFF, carry = 0, overflow = 0.
- SLT a = -1, b = 1 -> out_y = 1. SLTU a = 0xFFFFFFFF, b = 1 -> out_y = 0. NOR a = 0, b = 0 -> 0xFFFFFFFF.
- Opcode sweep 000..111 back-to-back with a = 1, b = -1, out_ready low for cycles 6-8:
  - in_ready = 0 during the stall and out_* held stable.
  - All 8 results emerge in order with no loss or duplication.
- flush pulsed while 3 ops are in flight and in_valid = 1 -> no out_valid for those 4 ops. The next accepted op appears 4 cycles after its accept.
- rst_n pulled low for 1 cycle with the pipeline full -> out_valid = 0 immediately; after release, in_ready = 1 and no stale result ever appears.
